// File: rtl/riscv_data_memory_responder_pkg.sv
// Shared constants and address-decode helper for the riscv_cpu data-memory responder.
// FSM encodings and MMIO register offsets live here so the top and bench agree on them.
package riscv_data_memory_responder_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [31:0] DMEM_MMIO_BASE = 32'h8000_0000;

  // Word index within the 16-byte MMIO window (address bits [3:2]).
  localparam logic [1:0] MMIO_GPIO_OUT = 2'd0;
  localparam logic [1:0] MMIO_GPIO_IN  = 2'd1;
  localparam logic [1:0] MMIO_CYCLE    = 2'd2;
  localparam logic [1:0] MMIO_STATUS   = 2'd3;

  typedef struct packed {
    logic misaligned;
    logic in_ram;
    logic in_mmio;
  } dmem_decode_t;

  function automatic dmem_decode_t dmem_decode(input logic [31:0] addr,
                                               input logic [31:0] mmio_base,
                                               input int unsigned ram_bytes_log2);
    dmem_decode_t d;
    d.misaligned = (addr[1:0] != 2'b00);
    d.in_ram     = ((addr >> ram_bytes_log2) == 32'd0);
    d.in_mmio    = (addr[31:4] == mmio_base[31:4]);
    return d;
  endfunction

endpackage

// File: rtl/riscv_data_memory_responder_dmem_sram.sv
// Single-port synchronous RAM with registered read data; maps onto a block RAM.
// Read data only updates when a read is enabled, so it holds through the response cycle.
module riscv_data_memory_responder_dmem_sram #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/riscv_data_memory_responder.sv
// Data-memory responder: RAM plus a four-register MMIO window behind a 1-cycle ready handshake.
// Every request completes in exactly one response cycle, faulting or not.
module riscv_data_memory_responder
  import riscv_data_memory_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = DMEM_MMIO_BASE,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       data_memory_address,
  input  logic [31:0]       data_memory_write_data,
  input  logic              data_memory_mem_write,
  input  logic              data_memory_mem_read,
  output logic [31:0]       data_memory_read_data,
  output logic              data_memory_ready,
  output logic              fault,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic [0:0]        r_state;
  logic [31:0]       r_cycle;
  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_gpio_s1;
  logic [GPIO_W-1:0] r_gpio_s2;
  logic              r_fault;
  logic [31:0]       r_rdata;
  logic              r_sel_ram;

  dmem_decode_t w_dec;
  logic         w_sample;
  logic         w_store;
  logic         w_bad;
  logic         w_ok;
  logic         w_mmio_hit;
  logic         w_ram_we;
  logic         w_ram_re;
  logic         w_mmio_wr;
  logic         w_mmio_rd;
  logic [1:0]   w_mmio_sel;
  logic         w_status_clr;
  logic [AW-1:0] w_ram_addr;
  logic [31:0]  w_ram_rdata;
  logic [31:0]  w_mmio_rdata;
  logic         w_resp;

  assign w_dec      = dmem_decode(data_memory_address, MMIO_BASE, AW + 2);
  // Requests are only taken in IDLE and never while reset is asserted.
  assign w_sample   = (r_state == ST_IDLE) && !reset &&
                      (data_memory_mem_write || data_memory_mem_read);
  assign w_store    = data_memory_mem_write;
  assign w_bad      = w_dec.misaligned || !(w_dec.in_ram || w_dec.in_mmio);
  assign w_ok       = w_sample && !w_bad;
  assign w_mmio_hit = w_dec.in_mmio && !w_dec.in_ram;
  assign w_mmio_sel = data_memory_address[3:2];
  assign w_ram_addr = data_memory_address[AW+1:2];

  assign w_ram_we     = w_ok && w_store && w_dec.in_ram;
  assign w_ram_re     = w_ok && !w_store && w_dec.in_ram;
  assign w_mmio_wr    = w_ok && w_store && w_mmio_hit;
  assign w_mmio_rd    = w_ok && !w_store && w_mmio_hit;
  assign w_status_clr = w_mmio_wr && (w_mmio_sel == MMIO_STATUS) && data_memory_write_data[0];

  riscv_data_memory_responder_dmem_sram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_sram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (data_memory_write_data),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_mmio_rdata = 32'h0;
    unique case (w_mmio_sel)
      MMIO_GPIO_OUT: w_mmio_rdata = 32'(r_gpio_out);
      MMIO_GPIO_IN:  w_mmio_rdata = 32'(r_gpio_s2);
      MMIO_CYCLE:    w_mmio_rdata = r_cycle;
      MMIO_STATUS:   w_mmio_rdata = {31'h0, r_fault};
      default:       w_mmio_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cycle    <= 32'h0;
      r_gpio_out <= '0;
      r_gpio_s1  <= '0;
      r_gpio_s2  <= '0;
      r_fault    <= 1'b0;
      r_rdata    <= 32'h0;
      r_sel_ram  <= 1'b0;
    end else begin
      r_cycle   <= r_cycle + 32'd1;
      r_gpio_s1 <= gpio_in;
      r_gpio_s2 <= r_gpio_s1;
      // A new fault on the same edge as a clear wins.
      r_fault   <= (r_fault && !w_status_clr) || (w_sample && w_bad);
      if (w_mmio_wr && (w_mmio_sel == MMIO_GPIO_OUT)) begin
        r_gpio_out <= data_memory_write_data[GPIO_W-1:0];
      end
      case (r_state)
        ST_IDLE: begin
          if (w_sample) begin
            r_state   <= ST_RESP;
            r_sel_ram <= w_ram_re;
            r_rdata   <= w_mmio_rd ? w_mmio_rdata : 32'h0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_sel_ram <= 1'b0;
          r_rdata   <= 32'h0;
        end
      endcase
    end
  end

  // Reset during the response cycle suppresses the pulse immediately.
  assign w_resp                = (r_state == ST_RESP) && !reset;
  assign data_memory_ready     = w_resp;
  assign data_memory_read_data = !w_resp ? 32'h0 : (r_sel_ram ? w_ram_rdata : r_rdata);
  assign fault                 = r_fault;
  assign gpio_out              = r_gpio_out;

endmodule

// File: tb/tb_riscv_data_memory_responder.sv
// Scoreboard bench for riscv_data_memory_responder: expected load data is queued at issue
// and compared when ready pulses.
module tb_riscv_data_memory_responder;

  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mw;
  logic        mr;
  logic [31:0] rdata;
  logic        ready;
  logic        fault;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in;

  int          checks = 0;
  int          errors = 0;
  int unsigned tb_cyc = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  riscv_data_memory_responder #(
    .RAM_WORDS (1024),
    .MMIO_BASE (MB),
    .GPIO_W    (8)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .data_memory_address    (addr),
    .data_memory_write_data (wdata),
    .data_memory_mem_write  (mw),
    .data_memory_mem_read   (mr),
    .data_memory_read_data  (rdata),
    .data_memory_ready      (ready),
    .fault                  (fault),
    .gpio_out               (gpio_out),
    .gpio_in                (gpio_in)
  );

  // Drives one request, holds it until ready (bounded), then lets the FSM return to IDLE.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output int unsigned samp);
    @(negedge clk);
    mw = w; mr = r; addr = a; wdata = d;
    rd = 32'h0; lat = -1; samp = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        rd = rdata; lat = i; samp = tb_cyc;
        break;
      end
    end
    mw = 1'b0; mr = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; mw = 1'b0; mr = 1'b0; addr = 32'h0; wdata = 32'h0; gpio_in = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    checks++; if (gpio_out !== 8'h0) begin errors++; $display("FAIL reset_gpio got %h want 0", gpio_out); end
    reset = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] ta [4] = '{32'h10, 32'h0, 32'hFFC, 32'h400};
    logic [31:0] td [4] = '{32'h1234_5678, 32'h1111_1111, 32'h89AB_CDEF, 32'h5555_AAAA};
    logic [31:0] rd, ex;
    int lat;
    int unsigned samp;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      access(1'b1, 1'b0, ta[i], td[i], rd, lat, samp);
      ex = exp_q.pop_front();
      checks++;
      if (lat != 1 || rd !== ex || fault !== 1'b0) begin
        errors++;
        $display("FAIL ram_store[%0d] lat=%0d rd=%h fault=%b want lat=1 rd=%h fault=0", i, lat, rd,
                 fault, ex);
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(td[i]);
      access(1'b0, 1'b1, ta[i], 32'h0, rd, lat, samp);
      ex = exp_q.pop_front();
      checks++;
      if (lat != 1 || rd !== ex) begin
        errors++;
        $display("FAIL ram_load[%0d] lat=%0d rd=%h want lat=1 rd=%h", i, lat, rd, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ones = 0, consec = 0, bad = 0;
    logic prev = 1'b0;
    @(negedge clk);
    mr = 1'b1; addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        ones++;
        if (prev) consec++;
        if (rdata !== 32'h1234_5678) bad++;
      end
      prev = ready;
    end
    mr = 1'b0;
    @(posedge clk);
    checks++; if (ones != 5) begin errors++; $display("FAIL b2b_count got %0d want 5", ones); end
    checks++; if (consec != 0) begin errors++; $display("FAIL b2b_adjacent got %0d want 0", consec); end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data bad=%0d want 0", bad); end
  endtask

  task automatic test_gpio();
    logic [31:0] rd, ex;
    int lat;
    int unsigned samp;
    exp_q.push_back(32'h0);
    access(1'b1, 1'b0, MB, 32'h0000_00A5, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (lat != 1 || rd !== ex) begin errors++; $display("FAIL gpio_store lat=%0d rd=%h want %h", lat, rd, ex); end
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL gpio_out got %h want a5", gpio_out); end
    exp_q.push_back(32'h0000_00A5);
    access(1'b0, 1'b1, MB, 32'h0, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL gpio_out_read got %h want %h", rd, ex); end
    gpio_in = 8'h3C;
    repeat (3) @(posedge clk);
    exp_q.push_back(32'h0000_003C);
    access(1'b0, 1'b1, MB + 32'h4, 32'h0, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL gpio_in_read got %h want %h", rd, ex); end
    access(1'b1, 1'b0, MB + 32'h4, 32'hFF, rd, lat, samp);
    exp_q.push_back(32'h0000_003C);
    access(1'b0, 1'b1, MB + 32'h4, 32'h0, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex || gpio_out !== 8'hA5) begin
      errors++; $display("FAIL gpio_in_ro got %h gpio_out=%h want %h gpio_out=a5", rd, gpio_out, ex);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] v1, v2, rd;
    int lat;
    int unsigned s1, s2, samp;
    access(1'b0, 1'b1, MB + 32'h8, 32'h0, v1, lat, s1);
    repeat (7) @(posedge clk);
    access(1'b0, 1'b1, MB + 32'h8, 32'h0, v2, lat, s2);
    checks++;
    if (v2 - v1 !== 32'(s2 - s1)) begin
      errors++; $display("FAIL cycle_delta got %0d want %0d", v2 - v1, s2 - s1);
    end
    @(negedge clk);
    force dut.r_cycle = 32'hFFFF_FFFF;
    #1 release dut.r_cycle;
    exp_q.push_back(32'h0);
    access(1'b0, 1'b1, MB + 32'h8, 32'h0, rd, lat, samp);
    v1 = exp_q.pop_front();
    checks++; if (rd !== v1) begin errors++; $display("FAIL cycle_wrap got %h want %h", rd, v1); end
  endtask

  task automatic test_fault();
    logic [31:0] rd, ex;
    int lat;
    int unsigned samp;
    exp_q.push_back(32'h0);
    access(1'b0, 1'b1, 32'h13, 32'h0, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (lat != 1 || rd !== ex || fault !== 1'b1) begin
      errors++; $display("FAIL fault_misaligned lat=%0d rd=%h fault=%b want 1 %h 1", lat, rd, fault, ex);
    end
    exp_q.push_back(32'h1);
    access(1'b0, 1'b1, MB + 32'hC, 32'h0, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL status_read got %h want %h", rd, ex); end
    access(1'b1, 1'b0, MB + 32'hC, 32'h0, rd, lat, samp);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL status_noclear got %b want 1", fault); end
    access(1'b1, 1'b0, MB + 32'hC, 32'h1, rd, lat, samp);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL status_clear got %b want 0", fault); end
    access(1'b1, 1'b0, 32'h11, 32'h0000_0BAD, rd, lat, samp);
    exp_q.push_back(32'h1234_5678);
    access(1'b0, 1'b1, 32'h10, 32'h0, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex || fault !== 1'b1) begin
      errors++; $display("FAIL fault_store_dropped rd=%h fault=%b want %h 1", rd, fault, ex);
    end
    access(1'b1, 1'b0, MB + 32'hC, 32'h1, rd, lat, samp);
    exp_q.push_back(32'h0);
    access(1'b0, 1'b1, MB + 32'h10, 32'h0, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (lat != 1 || rd !== ex || fault !== 1'b1) begin
      errors++; $display("FAIL fault_unmapped lat=%0d rd=%h fault=%b want 1 %h 1", lat, rd, fault, ex);
    end
    access(1'b1, 1'b0, MB + 32'hC, 32'h1, rd, lat, samp);
    exp_q.push_back(32'h0);
    access(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (lat != 1 || rd !== ex) begin errors++; $display("FAIL wr_rd_both rd=%h want %h", rd, ex); end
    exp_q.push_back(32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h20, 32'h0, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex || fault !== 1'b0) begin
      errors++; $display("FAIL wr_rd_both_data rd=%h fault=%b want %h 0", rd, fault, ex);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, ex;
    int lat;
    int unsigned samp, c_rst;
    access(1'b0, 1'b1, 32'h13, 32'h0, rd, lat, samp);
    @(negedge clk);
    mw = 1'b1; addr = 32'h40; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_resp ready=%b want 1", ready); end
    reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL mid_noready ready=%b rdata=%h want 0 0", ready, rdata);
    end
    @(posedge clk); #1;
    c_rst = tb_cyc;
    mw = 1'b0;
    checks++; if (ready !== 1'b0 || fault !== 1'b0 || gpio_out !== 8'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_outputs ready=%b fault=%b gpio=%h rdata=%h want all 0", ready, fault,
               gpio_out, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'hCAFE_F00D);
    access(1'b0, 1'b1, 32'h40, 32'h0, rd, lat, samp);
    ex = exp_q.pop_front();
    checks++; if (lat != 1 || rd !== ex) begin errors++; $display("FAIL mid_ram_kept rd=%h want %h", rd, ex); end
    access(1'b0, 1'b1, MB + 32'h8, 32'h0, rd, lat, samp);
    checks++; if (rd !== 32'(samp - c_rst - 1)) begin
      errors++; $display("FAIL cycle_after_reset got %0d want %0d", rd, samp - c_rst - 1);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_back_to_back();
    test_gpio();
    test_cycle();
    test_fault();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
